// File: rtl/ifu.sv
// Instruction fetch unit: fetches words, fills the ID register, and redirects
// on BEQ, with a one-entry skid buffer and a drop state.
module ifu (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        npc_sel,
    input  logic        zero,
    input  logic        stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_BUF   = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_q;
    logic [31:0] buf_q;
    logic [31:0] buf_pc_q;
    logic [31:0] tgt_q;

    logic        consume;
    logic        br;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign consume = id_valid_q & ~stall;
    assign br      = consume & npc_sel & zero;
    assign target  = id_pc_q + 32'd4
                   + {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
    assign pc_inc  = pc_q + 32'd4;

    // Request is live whenever we are not parked in the skid buffer.
    assign imem_req  = ~reset & (state_q != S_BUF);
    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;

    // Fetch FSM: ID register, skid buffer and redirect bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_instr_q <= 32'd0;
            id_pc_q    <= 32'd0;
            buf_q      <= 32'd0;
            buf_pc_q   <= 32'd0;
            tgt_q      <= 32'd0;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (br) begin
                        id_valid_q <= 1'b0;
                        if (imem_ack) begin
                            pc_q <= target;
                        end else begin
                            tgt_q   <= target;
                            state_q <= S_DROP;
                        end
                    end else if (imem_ack) begin
                        pc_q <= pc_inc;
                        if (!id_valid_q || !stall) begin
                            id_instr_q <= imem_rdata;
                            id_pc_q    <= pc_q;
                            id_valid_q <= 1'b1;
                        end else begin
                            buf_q    <= imem_rdata;
                            buf_pc_q <= pc_q;
                            state_q  <= S_BUF;
                        end
                    end else if (consume) begin
                        id_valid_q <= 1'b0;
                    end
                end
                S_BUF: begin
                    if (br) begin
                        pc_q       <= target;
                        id_valid_q <= 1'b0;
                        state_q    <= S_FETCH;
                    end else if (consume) begin
                        id_instr_q <= buf_q;
                        id_pc_q    <= buf_pc_q;
                        id_valid_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        pc_q    <= tgt_q;
                        state_q <= S_FETCH;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: sequential fetch, stall buffering, taken and
// not-taken BEQ, delayed-ack redirect, reset in DROP and PC wrap.
module tb_ifu;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        npc_sel;
    logic        zero;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [15:0] br_imm;

    int tests = 0;
    int fails = 0;

    ifu dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .npc_sel    (npc_sel),
        .zero       (zero),
        .stall      (stall),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: 0x3008 holds the BEQ, everything else tags its address.
    always_comb begin
        if (imem_addr == 32'h0000_3008)
            imem_rdata = {16'h1000, br_imm};
        else
            imem_rdata = {16'hE000, imem_addr[15:0]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        imem_ack = 1'b0;
        npc_sel  = 1'b0;
        zero     = 1'b0;
        stall    = 1'b0;
        #1;
        chk("rst_req_comb", {31'd0, imem_req}, 32'd0);
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", imem_addr, 32'h3000);
        reset = 1'b0;
    endtask

    // Leaves the bench in the cycle where the BEQ at 0x3008 sits in ID.
    task automatic boot();
        do_reset();
        imem_ack = 1'b1;
        tick();
        tick();
        tick();
        chk("boot_idpc", id_pc, 32'h3008);
    endtask

    initial begin
        br_imm = 16'h0003;

        // Sequential fetch, taken BEQ with immediate ack, stall buffering
        do_reset();
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_idpc", id_pc, 32'd0);
        imem_ack = 1'b1;
        #1;
        chk("c1_addr", imem_addr, 32'h3000);
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk("c2_addr", imem_addr, 32'h3004);
        chk("c2_idpc", id_pc, 32'h3000);
        chk("c2_valid", {31'd0, id_valid}, 32'd1);
        chk("c2_instr", id_instr, 32'hE000_3000);
        tick();
        chk("c3_addr", imem_addr, 32'h3008);
        chk("c3_idpc", id_pc, 32'h3004);
        tick();
        chk("c4_idpc", id_pc, 32'h3008);
        chk("c4_instr", id_instr, 32'h1000_0003);
        chk("c4_addr", imem_addr, 32'h300C);
        npc_sel = 1'b1;
        zero    = 1'b1;
        tick();
        npc_sel = 1'b0;
        zero    = 1'b0;
        chk("br_valid", {31'd0, id_valid}, 32'd0);
        chk("br_addr", imem_addr, 32'h3018);
        tick();
        chk("br_idpc", id_pc, 32'h3018);
        chk("br_instr", id_instr, 32'hE000_3018);
        chk("br_next", imem_addr, 32'h301C);
        stall = 1'b1;
        tick();
        chk("buf_req", {31'd0, imem_req}, 32'd0);
        chk("buf_addr", imem_addr, 32'h3020);
        chk("buf_idpc", id_pc, 32'h3018);
        tick();
        chk("buf_hold_req", {31'd0, imem_req}, 32'd0);
        chk("buf_hold_idpc", id_pc, 32'h3018);
        stall = 1'b0;
        tick();
        chk("unbuf_idpc", id_pc, 32'h301C);
        chk("unbuf_instr", id_instr, 32'hE000_301C);
        chk("unbuf_req", {31'd0, imem_req}, 32'd1);
        chk("unbuf_addr", imem_addr, 32'h3020);
        tick();
        chk("resume_idpc", id_pc, 32'h3020);
        chk("resume_addr", imem_addr, 32'h3024);

        // Taken BEQ with backward offset and ack delayed three cycles
        br_imm = 16'hFFFF;
        boot();
        chk("d_instr", id_instr, 32'h1000_FFFF);
        npc_sel  = 1'b1;
        zero     = 1'b1;
        imem_ack = 1'b0;
        tick();
        npc_sel = 1'b0;
        zero    = 1'b0;
        chk("drop_valid", {31'd0, id_valid}, 32'd0);
        chk("drop_req", {31'd0, imem_req}, 32'd1);
        chk("drop_addr0", imem_addr, 32'h300C);
        tick();
        chk("drop_addr1", imem_addr, 32'h300C);
        tick();
        chk("drop_addr2", imem_addr, 32'h300C);
        imem_ack = 1'b1;
        tick();
        chk("drop_tgt", imem_addr, 32'h3008);
        chk("drop_valid2", {31'd0, id_valid}, 32'd0);
        tick();
        chk("drop_idpc", id_pc, 32'h3008);
        chk("drop_vld3", {31'd0, id_valid}, 32'd1);

        // Reset while in DROP
        br_imm = 16'h0003;
        boot();
        npc_sel  = 1'b1;
        zero     = 1'b1;
        imem_ack = 1'b0;
        tick();
        npc_sel = 1'b0;
        zero    = 1'b0;
        chk("rd_addr", imem_addr, 32'h300C);
        reset = 1'b1;
        #1;
        chk("rd_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rd_pc", imem_addr, 32'h3000);
        chk("rd_valid", {31'd0, id_valid}, 32'd0);
        chk("rd_req2", {31'd0, imem_req}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rd_req3", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1;
        tick();
        chk("rd_idpc", id_pc, 32'h3000);
        chk("rd_vld", {31'd0, id_valid}, 32'd1);

        // BEQ not taken
        boot();
        npc_sel = 1'b1;
        zero    = 1'b0;
        tick();
        npc_sel = 1'b0;
        chk("nt_idpc", id_pc, 32'h300C);
        chk("nt_valid", {31'd0, id_valid}, 32'd1);
        chk("nt_addr", imem_addr, 32'h3010);

        // Branch to 0xFFFFFFFC then wrap to zero
        br_imm = 16'hF3FC;
        boot();
        npc_sel = 1'b1;
        zero    = 1'b1;
        tick();
        npc_sel = 1'b0;
        zero    = 1'b0;
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_idpc", id_pc, 32'hFFFF_FFFC);
        chk("wr_wrap", imem_addr, 32'h0000_0000);
        tick();
        chk("wr_idpc0", id_pc, 32'h0000_0000);
        chk("wr_instr0", id_instr, 32'hE000_0000);
        chk("wr_addr4", imem_addr, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: imem_req  out  1  fetch request to instruction memory.
REQ-004 SHALL provide: imem_addr  out  32  fetch byte address, word-aligned.
REQ-005 SHALL provide: imem_ack  in  1  completes the request in the cycle it is high with imem_req=1.
REQ-006 SHALL provide: imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-007 SHALL provide: npc_sel  in  1  decode stage flags the ID instruction as BEQ.
REQ-008 SHALL provide: zero  in  1  ALU equality result for the ID instruction.
REQ-009 SHALL provide: stall  in  1  decode cannot accept; ID register holds.
REQ-010 SHALL provide: id_valid  out  1  ID register holds a live instruction.
REQ-011 SHALL provide: id_instr  out  32  instruction in ID register.
REQ-012 SHALL provide: id_pc  out  32  byte address of id_instr.

Function
REQ-013 SHALL define consume = id_valid & !stall; decode takes id_instr in that cycle.
REQ-014 SHALL define br = consume & npc_sel & zero; target = id_pc + 4 + (sign-extend(id_instr[15:0]) << 2), modulo 2^32; no delay slot.
REQ-015 SHALL keep fetch PC register pc; imem_addr = pc at all times.
REQ-016 SHALL implement a 3-state FSM: FETCH, BUF, DROP; imem_req=1 in FETCH and DROP, 0 in BUF and during reset.
REQ-017 SHALL hold imem_addr stable from request assertion until the ack cycle.
REQ-018 FETCH, br: ack=1 -> discard rdata, pc<=target, id_valid<=0, stay FETCH; ack=0 -> tgt<=target, id_valid<=0, go DROP.
REQ-019 FETCH, !br, ack=1, (!id_valid | !stall) -> id_instr<=rdata, id_pc<=pc, id_valid<=1, pc<=pc+4.
REQ-020 FETCH, !br, ack=1, id_valid & stall -> buf<=rdata, buf_pc<=pc, pc<=pc+4, go BUF; ID register unchanged.
REQ-021 FETCH, !br, ack=0 -> id_valid<=0 if consume, else ID register unchanged.
REQ-022 BUF, stall -> hold all state; BUF, br -> discard buffer, pc<=target, id_valid<=0, go FETCH.
REQ-023 BUF, consume & !br -> id_instr<=buf, id_pc<=buf_pc, id_valid<=1, go FETCH.
REQ-024 DROP: imem_addr = old pc; on ack discard rdata, pc<=tgt, go FETCH; id_valid stays 0.
REQ-025 SHALL never deliver an instruction fetched before a taken branch after that branch is consumed.
REQ-026 SHALL deliver instructions in program order, none lost or duplicated, with stall held arbitrarily long.
REQ-027 SHALL sustain one instruction per cycle when imem_ack is high every cycle and stall=0.
REQ-028 pc wraps 0xFFFF_FFFC -> 0x0000_0000 without error.

Reset
REQ-029 reset=1 at an edge SHALL set pc=0x0000_3000, FSM=FETCH, id_valid=0, id_instr=0, id_pc=0, buf=0, buf_pc=0, tgt=0.
REQ-030 reset=1 SHALL force imem_req=0 in that cycle; first request (addr 0x0000_3000) in first cycle after reset deasserts.
REQ-031 reset mid-transaction (DROP or FETCH awaiting ack) SHALL abandon it; instruction memory shares the same reset.

Verification
REQ-032 Reset release, ack every cycle, stall=0 -> imem_addr 0x3000,0x3004,0x3008; id_pc 0x3000,0x3004 on consecutive cycles, id_valid=1 from second cycle.
REQ-033 ack in FETCH while stall=1 and id_valid=1 -> FSM=BUF, imem_req=0; stall released -> buffered word presented next cycle with correct id_pc, then fetch resumes at pc+4.
REQ-034 Consume BEQ at id_pc=0x3008, imm16=0x0003, zero=1, ack same cycle -> id_valid=0 next cycle, imem_addr=0x3018; no 0x300C instruction delivered.
REQ-035 Same BEQ with ack delayed 3 cycles -> DROP, imem_addr held at old pc until ack, then imem_addr=0x3018; imm16=0xFFFF -> target 0x3008.
REQ-036 BEQ consumed with zero=0 -> no redirect, sequential delivery continues.
REQ-037 reset asserted while in DROP -> next cycle pc=0x3000, id_valid=0, imem_req=0; after release fetch restarts at 0x3000.
